// File: rtl/peripheral_noc_router_output_arbiter.sv
// Wormhole output arbiter for a NoC router: round-robin packet arbitration with a registered output slot.
// Define PERIPHERAL_NOC_ARBITER_FIXED_PRIO_EN for fixed priority (lowest valid index wins, prio held at 0).
module peripheral_noc_router_output_arbiter #(
  parameter int FLIT_WIDTH = 32,
  parameter int INPUTS     = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUTS*FLIT_WIDTH-1:0] in_flit,
  input  logic [INPUTS-1:0]            in_last,
  input  logic [INPUTS-1:0]            in_valid,
  output logic [INPUTS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]        out_flit,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int          IW   = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam logic [IW:0] N_IN = (IW+1)'(INPUTS);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WORM = 1'b1
  } state_t;

  state_t                  r_state;
  logic [IW-1:0]           r_gnt;
  logic [IW-1:0]           r_prio;
  logic [FLIT_WIDTH-1:0]   r_out_flit;
  logic                    r_out_last;
  logic                    r_out_valid;

  logic                    w_accept;
  logic                    w_xfer;
  logic                    w_sel_valid;
  logic                    w_sel_last;
  logic [IW-1:0]           w_sel;
  logic [IW-1:0]           w_prio_next;
  logic [IW:0]             w_idx;
  logic [IW:0]             w_inc;
  logic [FLIT_WIDTH-1:0]   w_sel_flit;

  // Input selection: locked input while a worm is open, otherwise first valid from prio upward.
  always_comb begin
    w_sel       = '0;
    w_sel_valid = 1'b0;
    w_idx       = '0;
    if (r_state == S_WORM) begin
      w_sel       = r_gnt;
      w_sel_valid = in_valid[r_gnt];
    end else begin
      // Descending scan so the smallest offset from prio is the last (winning) assignment.
      for (int k = INPUTS - 1; k >= 0; k--) begin
        w_idx = {1'b0, r_prio} + (IW+1)'(k);
        if (w_idx >= N_IN) begin
          w_idx = w_idx - N_IN;
        end else begin
          w_idx = w_idx;
        end
        if (in_valid[w_idx[IW-1:0]]) begin
          w_sel       = w_idx[IW-1:0];
          w_sel_valid = 1'b1;
        end else begin
          w_sel       = w_sel;
          w_sel_valid = w_sel_valid;
        end
      end
    end
  end

  assign w_accept    = ~r_out_valid | out_ready;
  assign w_xfer      = w_accept & w_sel_valid;
  assign w_sel_flit  = in_flit[int'(w_sel)*FLIT_WIDTH +: FLIT_WIDTH];
  assign w_sel_last  = in_last[w_sel];
  assign w_inc       = {1'b0, w_sel} + (IW+1)'(1);
  assign w_prio_next = (w_inc == N_IN) ? '0 : w_inc[IW-1:0];

  // One-hot ready toward the selected input only.
  always_comb begin
    in_ready = '0;
    if (w_xfer) begin
      in_ready[w_sel] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Arbitration state and the registered output slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_prio      <= '0;
      r_out_flit  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out_flit  <= w_sel_flit;
      r_out_last  <= w_sel_last;
      r_out_valid <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (!w_sel_last) begin
            r_state <= S_WORM;
            r_gnt   <= w_sel;
          end else begin
`ifdef PERIPHERAL_NOC_ARBITER_FIXED_PRIO_EN
            r_prio  <= '0;
`else
            r_prio  <= w_prio_next;
`endif
          end
        end
        S_WORM: begin
          if (w_sel_last) begin
            r_state <= S_IDLE;
`ifdef PERIPHERAL_NOC_ARBITER_FIXED_PRIO_EN
            r_prio  <= '0;
`else
            r_prio  <= w_prio_next;
`endif
          end else begin
            r_state <= S_WORM;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_flit  = r_out_flit;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_peripheral_noc_router_output_arbiter.sv
// Self-checking bench for peripheral_noc_router_output_arbiter: directed scenarios plus random traffic
// compared against a packet-level arbitration model.
module tb_peripheral_noc_router_output_arbiter;

  localparam int N  = 5;
  localparam int FW = 32;

  logic            clk;
  logic            rst;
  logic [N*FW-1:0] in_flit;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [FW-1:0]   out_flit;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;

  int n_tests;
  int n_fail;

  peripheral_noc_router_output_arbiter #(.FLIT_WIDTH(FW), .INPUTS(N)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: lock = input owning an open packet (-1 none), prio = round-robin start.
  int           m_lock;
  int           m_prio;
  int           m_sel;
  logic         m_xfer;
  logic [N-1:0] m_ready;
  logic         m_ov;
  logic         m_ol;
  logic [FW-1:0] m_of;

  function automatic int model_sel(input int lock, input int prio, input logic [N-1:0] v);
    if (lock >= 0) return v[lock] ? lock : -1;
    for (int k = 0; k < N; k++) begin
      int j = (prio + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  always_comb begin
    m_sel   = model_sel(m_lock, m_prio, in_valid);
    m_xfer  = ((!m_ov) || out_ready) && (m_sel >= 0);
    m_ready = '0;
    if (m_xfer) m_ready[m_sel] = 1'b1;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lock <= -1;
      m_prio <= 0;
      m_ov   <= 1'b0;
      m_ol   <= 1'b0;
      m_of   <= '0;
    end else if (m_xfer) begin
      m_ov <= 1'b1;
      m_of <= in_flit[m_sel*FW +: FW];
      m_ol <= in_last[m_sel];
      if (in_last[m_sel]) begin
        m_lock <= -1;
`ifdef PERIPHERAL_NOC_ARBITER_FIXED_PRIO_EN
        m_prio <= 0;
`else
        m_prio <= (m_sel + 1) % N;
`endif
      end else begin
        m_lock <= m_sel;
      end
    end else if (m_ov && out_ready) begin
      m_ov <= 1'b0;
    end
  end

  task automatic drive(input int i, input logic v, input logic l, input logic [FW-1:0] f);
    in_valid[i]         = v;
    in_last[i]          = l;
    in_flit[i*FW +: FW] = f;
  endtask

  task automatic clr();
    in_valid = '0;
    in_last  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_flit !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b l=%b f=%h expected 0/0/0", out_valid, out_last, out_flit);
    end
    n_tests++;
    if (in_ready !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 00000", in_ready);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
  endtask

  task automatic test_rr_single();
    out_ready = 1'b1;
    drive(0, 1'b1, 1'b1, 32'h1000_0000);
    drive(2, 1'b1, 1'b1, 32'h1200_0000);
    #1;
    n_tests++;
    if (in_ready !== 5'b00001) begin n_fail++; $display("FAIL rr_ready0: got %b expected 00001", in_ready); end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_flit !== 32'h1000_0000) begin
      n_fail++; $display("FAIL rr_out0: got v=%b f=%h expected 1/10000000", out_valid, out_flit);
    end
    drive(0, 1'b0, 1'b0, 32'h0);
    #1;
    n_tests++;
    if (in_ready !== 5'b00100) begin n_fail++; $display("FAIL rr_ready2: got %b expected 00100", in_ready); end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_flit !== 32'h1200_0000) begin
      n_fail++; $display("FAIL rr_out2: got v=%b f=%h expected 1/12000000", out_valid, out_flit);
    end
    // prio should now be 3: with inputs 1 and 3 both requesting, 3 must win.
    clr();
    drive(1, 1'b1, 1'b1, 32'h1100_0000);
    drive(3, 1'b1, 1'b1, 32'h1300_0000);
    #1;
    n_tests++;
    if (in_ready !== 5'b01000) begin n_fail++; $display("FAIL rr_prio3: got %b expected 01000", in_ready); end
    tick();
    n_tests++;
    if (out_flit !== 32'h1300_0000) begin n_fail++; $display("FAIL rr_out3: got %h expected 13000000", out_flit); end
    clr();
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_worm();
    // prio is 4: search order 4,0,1 picks input 1 ahead of input 3
    drive(3, 1'b1, 1'b1, 32'h1300_0000);
    for (int f = 1; f <= 4; f++) begin
      drive(1, 1'b1, (f == 4), 32'h1100_0000 + 32'(f));
      #1;
      n_tests++;
      if (in_ready !== 5'b00010) begin n_fail++; $display("FAIL worm_ready[%0d]: got %b expected 00010", f, in_ready); end
      tick();
      n_tests++;
      if (out_flit !== 32'h1100_0000 + 32'(f) || out_last !== (f == 4)) begin
        n_fail++; $display("FAIL worm_out[%0d]: got f=%h l=%b expected %h/%b", f, out_flit, out_last, 32'h1100_0000 + 32'(f), (f == 4));
      end
    end
    drive(1, 1'b0, 1'b0, 32'h0);
    #1;
    n_tests++;
    if (in_ready !== 5'b01000) begin n_fail++; $display("FAIL worm_next_ready: got %b expected 01000", in_ready); end
    tick();
    n_tests++;
    if (out_flit !== 32'h1300_0000) begin n_fail++; $display("FAIL worm_next_out: got %h expected 13000000", out_flit); end
    clr();
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(2, 1'b1, 1'b1, 32'hA5A5_A5A5);
    #1;
    n_tests++;
    if (in_ready !== 5'b00100) begin n_fail++; $display("FAIL bp_first_ready: got %b expected 00100", in_ready); end
    tick();
    drive(2, 1'b1, 1'b1, 32'h5A5A_5A5A);
    drive(0, 1'b1, 1'b1, 32'h1000_0010);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (in_ready !== 5'b00000 || out_valid !== 1'b1 || out_flit !== 32'hA5A5_A5A5) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got r=%b v=%b f=%h expected 00000/1/a5a5a5a5", c, in_ready, out_valid, out_flit);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 5'b00001) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 00001", in_ready); end
    tick();
    n_tests++;
    if (out_flit !== 32'h1000_0010) begin n_fail++; $display("FAIL bp_release_out: got %h expected 10000010", out_flit); end
    drive(0, 1'b0, 1'b0, 32'h0);
    #1;
    n_tests++;
    if (in_ready !== 5'b00100) begin n_fail++; $display("FAIL bp_next_ready: got %b expected 00100", in_ready); end
    tick();
    n_tests++;
    if (out_flit !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL bp_next_out: got %h expected 5a5a5a5a", out_flit); end
    clr();
    tick();
  endtask

  task automatic test_bubble();
    // prio is 3: input 4 wins over input 0
    drive(0, 1'b1, 1'b1, 32'h1000_0099);
    drive(4, 1'b1, 1'b0, 32'h1400_0001);
    #1;
    n_tests++;
    if (in_ready !== 5'b10000) begin n_fail++; $display("FAIL bub_first_ready: got %b expected 10000", in_ready); end
    tick();
    drive(4, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_tests++;
      if (in_ready !== 5'b00000) begin n_fail++; $display("FAIL bub_lock[%0d]: got %b expected 00000", c, in_ready); end
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bub_empty: got %b expected 0", out_valid); end
    for (int f = 2; f <= 3; f++) begin
      drive(4, 1'b1, (f == 3), 32'h1400_0000 + 32'(f));
      #1;
      n_tests++;
      if (in_ready !== 5'b10000) begin n_fail++; $display("FAIL bub_ready[%0d]: got %b expected 10000", f, in_ready); end
      tick();
      n_tests++;
      if (out_flit !== 32'h1400_0000 + 32'(f)) begin n_fail++; $display("FAIL bub_out[%0d]: got %h expected %h", f, out_flit, 32'h1400_0000 + 32'(f)); end
    end
    drive(4, 1'b0, 1'b0, 32'h0);
    #1;
    n_tests++;
    if (in_ready !== 5'b00001) begin n_fail++; $display("FAIL bub_after_ready: got %b expected 00001", in_ready); end
    tick();
    n_tests++;
    if (out_flit !== 32'h1000_0099) begin n_fail++; $display("FAIL bub_after_out: got %h expected 10000099", out_flit); end
    clr();
    tick();
  endtask

  task automatic test_reset_mid_worm();
    // prio is 1: input 2 opens a worm, held at the output by backpressure
    out_ready = 1'b0;
    drive(2, 1'b1, 1'b0, 32'h1200_0001);
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_flit !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: got v=%b l=%b f=%h expected 0/0/0", out_valid, out_last, out_flit);
    end
    clr();
    @(posedge clk);
    #3 rst = 1'b1;
    out_ready = 1'b1;
    drive(1, 1'b1, 1'b1, 32'h1100_0077);
    drive(3, 1'b1, 1'b1, 32'h1300_0077);
    #1;
    n_tests++;
    if (in_ready !== 5'b00010) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 00010", in_ready); end
    tick();
    n_tests++;
    if (out_flit !== 32'h1100_0077) begin n_fail++; $display("FAIL rstmid_out: got %h expected 11000077", out_flit); end
    clr();
    tick();
  endtask

  task automatic test_fixed_prio();
    out_ready = 1'b1;
    drive(0, 1'b1, 1'b1, 32'h1000_0000);
    drive(1, 1'b1, 1'b1, 32'h1100_0000);
    for (int c = 0; c < 8; c++) begin
      #1;
      n_tests++;
      if (in_ready !== 5'b00001) begin n_fail++; $display("FAIL fixed_ready[%0d]: got %b expected 00001", c, in_ready); end
      tick();
      n_tests++;
      if (out_flit !== 32'h1000_0000) begin n_fail++; $display("FAIL fixed_out[%0d]: got %h expected 10000000", c, out_flit); end
    end
    clr();
    tick();
  endtask

  task automatic test_random();
    int           g_pkt[N];
    int           g_idx[N];
    int           g_len[N];
    logic [N-1:0] xv;
    int           open_src;
    open_src = -1;
    for (int i = 0; i < N; i++) begin
      g_pkt[i] = 0;
      g_idx[i] = 0;
      g_len[i] = int'($urandom_range(1, 4));
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        drive(i, ($urandom_range(0, 9) < 6), (g_idx[i] == g_len[i] - 1),
              {4'(i), 12'(g_pkt[i]), 16'(g_idx[i])});
      end
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      n_tests++;
      if (in_ready !== m_ready) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, in_ready, m_ready); end
      xv = in_valid & m_ready;
      if (out_valid && out_ready) begin
        if (open_src >= 0) begin
          n_tests++;
          if (int'(out_flit[31:28]) != open_src) begin
            n_fail++; $display("FAIL rnd_interleave[%0d]: got src %0d expected %0d", c, out_flit[31:28], open_src);
          end
        end
        open_src = out_last ? -1 : int'(out_flit[31:28]);
      end
      tick();
      n_tests++;
      if (out_valid !== m_ov || (m_ov && (out_flit !== m_of || out_last !== m_ol))) begin
        n_fail++; $display("FAIL rnd_out[%0d]: got v=%b f=%h l=%b expected v=%b f=%h l=%b", c, out_valid, out_flit, out_last, m_ov, m_of, m_ol);
      end
      for (int i = 0; i < N; i++) begin
        if (xv[i]) begin
          if (g_idx[i] == g_len[i] - 1) begin
            g_pkt[i]++;
            g_idx[i] = 0;
            g_len[i] = int'($urandom_range(1, 4));
          end else begin
            g_idx[i]++;
          end
        end
      end
    end
    clr();
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    out_ready = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    in_flit   = '0;
    n_tests   = 0;
    n_fail    = 0;
    test_reset();
`ifndef PERIPHERAL_NOC_ARBITER_FIXED_PRIO_EN
    test_rr_single();
    test_worm();
    test_backpressure();
    test_bubble();
    test_reset_mid_worm();
`else
    test_fixed_prio();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/peripheral_noc_router_output_arbiter.md
PERIPHERAL_NOC_ROUTER_OUTPUT_ARBITER -- requirements
Module: peripheral_noc_router_output_arbiter

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 32, meaning the flit width in bits.
REQ-002 SHALL have parameter INPUTS, default 5, meaning the number of competing input ports; legal range 2..16.
REQ-003 SHALL have port clk  input  1  the single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_flit  input  INPUTS*FLIT_WIDTH  flits; input i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH].
REQ-006 SHALL have port in_last  input  INPUTS  per-input last-flit-of-packet flag.
REQ-007 SHALL have port in_valid  input  INPUTS  per-input valid, one bit per lookup stage that targets this output.
REQ-008 SHALL have port in_ready  output  INPUTS  per-input ready.
REQ-009 SHALL have port out_flit  output  FLIT_WIDTH  registered flit.
REQ-010 SHALL have port out_last  output  1  registered last flag.
REQ-011 SHALL have port out_valid  output  1  registered valid.
REQ-012 SHALL have port out_ready  input  1  downstream ready.

Function
REQ-013 SHALL transfer a flit on input i when in_valid[i] and in_ready[i] are both high at a rising clk edge; the output transfers when out_valid and out_ready are both high.
REQ-014 SHALL compute accept = !out_valid | out_ready; in_ready[i] SHALL be high only when accept is high and i is the selected input, so at most one in_ready bit is high per cycle.
REQ-015 SHALL load the selected input's flit and last flag into out_flit/out_last and set out_valid on an input transfer, giving a latency of exactly 1 cycle.
REQ-016 SHALL clear out_valid when an output transfer occurs with no input transfer in the same cycle; otherwise it SHALL hold out_flit, out_last and out_valid.
REQ-017 SHALL implement states IDLE and WORM, plus a registered grant index gnt and a priority pointer prio.
REQ-018 In IDLE, SHALL select the first input with in_valid high, searching from prio upward and wrapping modulo INPUTS.
REQ-019 In IDLE, on a transfer with in_last=0, SHALL enter WORM with gnt set to the selected input.
REQ-020 In IDLE, on a transfer with in_last=1 (single-flit packet), SHALL stay in IDLE and set prio to (selected+1) mod INPUTS.
REQ-021 In WORM, SHALL select only gnt; all other inputs' in_ready SHALL be low regardless of their in_valid.
REQ-022 In WORM, a gnt transfer with in_last=1 SHALL return to IDLE and set prio to (gnt+1) mod INPUTS.
REQ-023 In WORM, in_valid[gnt] low (a bubble) SHALL keep the WORM state and the lock.
REQ-024 With no input valid, or accept low, SHALL transfer nothing and change no state.
REQ-025 SHALL never drop or duplicate a flit and SHALL never interleave flits from different packets.

Reset
REQ-026 While rst is low, SHALL force state=IDLE, prio=0, gnt=0, out_valid=0, out_last=0 and out_flit=0, asynchronously.
REQ-027 Reset asserted mid-worm SHALL discard the held flit and the lock; the first packet after reset SHALL be arbitrated from prio=0.

Configuration
REQ-028 Macro PERIPHERAL_NOC_ARBITER_FIXED_PRIO_EN: when defined, the IDLE selection SHALL be fixed priority (the lowest valid index wins) and prio SHALL remain 0; when undefined, round-robin per REQ-018/020/022 applies.

Verification
REQ-029 After reset, inputs 0 and 2 each send a 1-flit packet at cycle 0 with out_ready=1 -> input 0 appears at cycle 1 and input 2 at cycle 2; prio is 3 afterwards.
REQ-030 Input 1 sends a 4-flit worm while input 3 is continuously valid -> 4 contiguous flits from input 1 appear, then input 3's flit; in_ready[3] stays 0 throughout the worm.
REQ-031 With out_ready=0 for 3 cycles, holding flit 0xA5A5A5A5 -> out_flit is stable and out_valid stays 1, all in_ready are 0, and there is no loss when out_ready rises.
REQ-032 Input 4 drops in_valid for 2 cycles mid-worm while input 0 is valid -> the lock is kept, and the worm completes before input 0 is granted.
REQ-033 Assert rst low mid-worm, then release -> all outputs read 0, and the next request from inputs 3 and 1 grants input 1 first.
REQ-034 With PERIPHERAL_NOC_ARBITER_FIXED_PRIO_EN defined and inputs 0 and 1 always valid with 1-flit packets -> only input 0 is served.
